// File: rtl/wb_common_pkg.sv
// Wishbone B3 cycle-type / burst-type encodings shared by bus slaves,
// plus the state type of the burst RAM controller.
package wb_common_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ram_state_t;

endpackage

// File: rtl/wb_burst_adr_gen.sv
// Next beat address for an incrementing burst: +4 with only the low bits
// inside the wrap block (16/32/64 bytes, or the whole RAM) allowed to change.
module wb_burst_adr_gen
  import wb_common_pkg::*;
#(
  parameter int aw    = 32,
  parameter int depth = 32768
) (
  input  logic [aw-1:0] adr,
  input  logic [1:0]    bte,
  output logic [aw-1:0] next_adr
);

  logic [aw-1:0] wrap_mask;
  logic [aw-1:0] inc_adr;

  always_comb begin
    wrap_mask = aw'(depth - 1);
    case (bte)
      BTE_WRAP4:  wrap_mask = aw'(16 - 1);
      BTE_WRAP8:  wrap_mask = aw'(32 - 1);
      BTE_WRAP16: wrap_mask = aw'(64 - 1);
      default:    wrap_mask = aw'(depth - 1);
    endcase
  end

  assign inc_adr  = adr + aw'(4);
  assign next_adr = (adr & ~wrap_mask) | (inc_adr & wrap_mask);

endmodule

// File: rtl/wb_burst_ram.sv
// Wishbone B3 single-port RAM with registered feedback bursts (1 beat/cycle),
// byte-lane writes and an error response for beats beyond the RAM size.
module wb_burst_ram
  import wb_common_pkg::*;
#(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int depth   = 32768,
  parameter     memfile = ""
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int depth_log2 = $clog2(depth);
  localparam int idx_w      = depth_log2 - 2;
  localparam int words      = depth / 4;

  ram_state_t    state_reg, state_next;
  logic [aw-1:0] adr_reg, adr_next;
  logic [aw-1:0] burst_adr;
  logic          ack_reg, ack_next;
  logic          err_reg, err_next;
  logic          mem_we;
  logic [idx_w-1:0] wr_idx, rd_idx;

  // The full byte address is latched so that beats past the RAM size are
  // recognised; only the word-index bits address the array.
  function automatic logic beyond_depth(input logic [aw-1:0] a);
    return (a >> depth_log2) != '0;
  endfunction

  wb_burst_adr_gen #(
    .aw    (aw),
    .depth (depth)
  ) u_adr_gen (
    .adr      (adr_reg),
    .bte      (wb_bte_i),
    .next_adr (burst_adr)
  );

  always_comb begin
    state_next = state_reg;
    adr_next   = adr_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    mem_we     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i && !ack_reg) begin
          state_next = ST_ACTIVE;
          adr_next   = wb_adr_i;
          ack_next   = !beyond_depth(wb_adr_i);
          err_next   = beyond_depth(wb_adr_i);
        end
      end
      ST_ACTIVE: begin
        if (!wb_cyc_i) begin
          state_next = ST_IDLE;
        end else if (wb_stb_i) begin
          if (err_reg) begin
            state_next = ST_IDLE;
          end else if (ack_reg) begin
            mem_we = wb_we_i && !wb_rst_i;
            if (wb_cti_i == CTI_INC) begin
              adr_next = burst_adr;
              ack_next = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            // Master resumed after a wait state: answer the held beat again.
            ack_next = !beyond_depth(adr_reg);
            err_next = beyond_depth(adr_reg);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= ST_IDLE;
      adr_reg   <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      adr_reg   <= adr_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
    end
  end

  assign wr_idx = adr_reg[depth_log2-1:2];
  assign rd_idx = adr_next[depth_log2-1:2];

  // One byte-wide RAM per lane gives per-byte write enables; the read port is
  // registered and cleared whenever the next cycle carries no ack.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [words];
    logic [7:0] lane_dat_reg;

    always_ff @(posedge wb_clk_i) begin
      if (mem_we && wb_sel_i[gi]) begin
        lane_mem[wr_idx] <= wb_dat_i[8*gi +: 8];
      end
      if (wb_rst_i || !ack_next) begin
        lane_dat_reg <= '0;
      end else begin
        lane_dat_reg <= lane_mem[rd_idx];
      end
    end

    assign wb_dat_o[8*gi +: 8] = lane_dat_reg;
  end

  assign wb_ack_o = ack_reg;
  assign wb_err_o = err_reg;
  assign wb_rty_o = 1'b0;

endmodule
